// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default constants for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

    // Sequencer state: normal flow, or frozen behind a multi-cycle memory access.
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam int DEF_REG_W       = 5;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_MEM_TIMEOUT = 255;

    // Index of the hardwired zero register; writes to it never create a dependency.
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently in EX.
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = DEF_REG_W
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    output logic             load_use
);

    localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(REG_ZERO);

    // A load into register zero produces nothing to wait for, so it is ignored.
    always_comb begin
        load_use = ex_mem_read
                 & (ex_rd != ZERO_IDX)
                 & ((ex_rd == id_rs) | (ex_rd == id_rt));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the IF/ID, ID/EX, EX/MEM, MEM/WB registers and the PC.
// Decides advance / hold / bubble each cycle, counts stalled cycles and
// reports memory accesses that wait too long.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W       = DEF_REG_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             mem_timeout
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  STALL_MAX = '1;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_inc;
    logic              mem_stall;
    logic              load_use;

    // Raw (pre-reset-gating) control decisions.
    logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
    logic ifid_flush_c, idex_flush_c, memwb_flush_c;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    assign mem_stall = mem_req & ~mem_ack;

    // Priority mux: memory freeze beats branch flush beats load-use bubble.
    always_comb begin
        // NOTE: every output gets a default before the priority chain so no path leaves it unassigned (no latch).
        pc_en_c       = 1'b1;
        ifid_en_c     = 1'b1;
        idex_en_c     = 1'b1;
        exmem_en_c    = 1'b1;
        memwb_en_c    = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        memwb_flush_c = 1'b0;
        if (mem_stall) begin
            // Front of the pipe holds (including any taken branch in EX);
            // WB receives a bubble while MEM is busy.
            pc_en_c       = 1'b0;
            ifid_en_c     = 1'b0;
            idex_en_c     = 1'b0;
            exmem_en_c    = 1'b0;
            memwb_flush_c = 1'b1;
        end else if (ex_branch_taken) begin
            // Squash the two wrong-path instructions; this also removes any
            // load-use dependent sitting in ID.
            ifid_flush_c  = 1'b1;
            idex_flush_c  = 1'b1;
        end else if (load_use) begin
            pc_en_c       = 1'b0;
            ifid_en_c     = 1'b0;
            idex_flush_c  = 1'b1;
        end
    end

    // Reset forces all enables and flushes low regardless of the clock.
    always_comb begin
        pc_en       = pc_en_c       & reset;
        ifid_en     = ifid_en_c     & reset;
        idex_en     = idex_en_c     & reset;
        exmem_en    = exmem_en_c    & reset;
        memwb_en    = memwb_en_c    & reset;
        ifid_flush  = ifid_flush_c  & reset;
        idex_flush  = idex_flush_c  & reset;
        memwb_flush = memwb_flush_c & reset;
    end

    // Next-state logic: enter MEM_WAIT on an un-acked access, leave on ack.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      if (mem_stall) state_nxt = MEM_WAIT;
            MEM_WAIT: if (mem_ack)   state_nxt = RUN;
            default:                 state_nxt = RUN;
        endcase
    end

    // Saturating successor of the wait counter.
    always_comb begin
        wait_cnt_inc = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_W'(1);
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) state <= RUN;
        else        state <= state_nxt;
    end

    // Wait counter and sticky timeout flag; the flag is report-only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (state == RUN) begin
            if (state_nxt == MEM_WAIT) wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_inc;
            if (!mem_ack && (wait_cnt_inc == WAIT_MAX)) mem_timeout <= 1'b1;
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (!pc_en && (stall_cycles != STALL_MAX)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Instance A uses default parameters;
// instance B shares the stimulus with MEM_TIMEOUT=3 and a 3-bit stall counter
// to reach the timeout and saturation boundaries quickly.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    // Packed control view: {pc, ifid, idex, exmem, memwb enables, ifid/idex/memwb flushes}
    localparam logic [7:0] CTL_RESET  = 8'b00000_000;
    localparam logic [7:0] CTL_NORMAL = 8'b11111_000;
    localparam logic [7:0] CTL_LDUSE  = 8'b00111_010;
    localparam logic [7:0] CTL_BRANCH = 8'b11111_110;
    localparam logic [7:0] CTL_MEMST  = 8'b00001_001;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic       ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
    logic       mem_req = 1'b0, mem_ack = 1'b0;

    logic        pc_en_a, ifid_en_a, idex_en_a, exmem_en_a, memwb_en_a;
    logic        ifid_flush_a, idex_flush_a, memwb_flush_a, mem_timeout_a;
    logic [15:0] stall_cycles_a;
    logic        pc_en_b, ifid_en_b, idex_en_b, exmem_en_b, memwb_en_b;
    logic        ifid_flush_b, idex_flush_b, memwb_flush_b, mem_timeout_b;
    logic [2:0]  stall_cycles_b;
    logic [7:0]  ctl_a, ctl_b;

    int n_cmp = 0;
    int n_err = 0;

    assign ctl_a = {pc_en_a, ifid_en_a, idex_en_a, exmem_en_a, memwb_en_a,
                    ifid_flush_a, idex_flush_a, memwb_flush_a};
    assign ctl_b = {pc_en_b, ifid_en_b, idex_en_b, exmem_en_b, memwb_en_b,
                    ifid_flush_b, idex_flush_b, memwb_flush_b};

    pipe_hazard_ctrl dut_a (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en_a), .ifid_en(ifid_en_a), .idex_en(idex_en_a),
        .exmem_en(exmem_en_a), .memwb_en(memwb_en_a),
        .ifid_flush(ifid_flush_a), .idex_flush(idex_flush_a), .memwb_flush(memwb_flush_a),
        .stall_cycles(stall_cycles_a), .mem_timeout(mem_timeout_a)
    );

    pipe_hazard_ctrl #(.REG_W(5), .CNT_W(3), .MEM_TIMEOUT(3)) dut_b (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en_b), .ifid_en(ifid_en_b), .idex_en(idex_en_b),
        .exmem_en(exmem_en_b), .memwb_en(memwb_en_b),
        .ifid_flush(ifid_flush_b), .idex_flush(idex_flush_b), .memwb_flush(memwb_flush_b),
        .stall_cycles(stall_cycles_b), .mem_timeout(mem_timeout_b)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = '0; id_rt = '0; ex_rd = '0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #3;
        check("rst_ctl",    32'(ctl_a), 32'(CTL_RESET));
        check("rst_state",  32'(dut_a.state), 32'(RUN));
        check("rst_stall",  32'(stall_cycles_a), 32'd0);
        check("rst_tmo",    32'(mem_timeout_a), 32'd0);
        #9 reset = 1'b1;           // released between edges
        step();
        #1 check("idle_ctl", 32'(ctl_a), 32'(CTL_NORMAL));

        // Load-use via id_rs
        ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs = 5'd3; id_rt = 5'd9;
        #1 check("lu_rs_ctl", 32'(ctl_a), 32'(CTL_LDUSE));
        step();
        check("lu_rs_stall", 32'(stall_cycles_a), 32'd1);
        idle_inputs();
        #1 check("lu_rs_after", 32'(ctl_a), 32'(CTL_NORMAL));

        // Load-use via id_rt
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs = 5'd1; id_rt = 5'd7;
        #1 check("lu_rt_ctl", 32'(ctl_a), 32'(CTL_LDUSE));
        step();
        check("lu_rt_stall", 32'(stall_cycles_a), 32'd2);

        // Same registers but not a load: no hazard
        ex_mem_read = 1'b0;
        #1 check("nolu_ctl", 32'(ctl_a), 32'(CTL_NORMAL));

        // Zero-register guard
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        #1 check("zero_ctl", 32'(ctl_a), 32'(CTL_NORMAL));
        step();
        check("zero_stall", 32'(stall_cycles_a), 32'd2);

        // Branch plus load-use: branch wins
        ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs = 5'd3;
        #1 check("br_lu_ctl", 32'(ctl_a), 32'(CTL_BRANCH));
        step();
        check("br_lu_stall", 32'(stall_cycles_a), 32'd2);
        idle_inputs();

        // Request acked in the same cycle: no stall
        mem_req = 1'b1; mem_ack = 1'b1;
        #1 check("ack0_ctl", 32'(ctl_a), 32'(CTL_NORMAL));
        step();
        check("ack0_state", 32'(dut_a.state), 32'(RUN));
        check("ack0_stall", 32'(stall_cycles_a), 32'd2);

        // 4-cycle memory wait with a taken branch held in EX
        mem_req = 1'b1; mem_ack = 1'b0; ex_branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check($sformatf("mw_ctl%0d", i), 32'(ctl_a), 32'(CTL_MEMST));
            step();
            check($sformatf("mw_state%0d", i), 32'(dut_a.state), 32'(MEM_WAIT));
        end
        mem_ack = 1'b1;
        #1 check("mw_release_ctl", 32'(ctl_a), 32'(CTL_BRANCH));
        step();
        check("mw_end_state", 32'(dut_a.state), 32'(RUN));
        check("mw_end_stall", 32'(stall_cycles_a), 32'd6);
        check("mw_tmo_dflt",  32'(mem_timeout_a), 32'd0);
        check("mw_tmo_b",     32'(mem_timeout_b), 32'd1);
        idle_inputs();

        // Async reset in the middle of a memory wait
        mem_req = 1'b1;
        step();
        step();
        check("ar_state_pre", 32'(dut_a.state), 32'(MEM_WAIT));
        check("ar_stall_a",   32'(stall_cycles_a), 32'd8);
        check("ar_stall_sat", 32'(stall_cycles_b), 32'd7);
        #1 reset = 1'b0;
        #1;
        check("ar_ctl",    32'(ctl_a), 32'(CTL_RESET));
        check("ar_state",  32'(dut_a.state), 32'(RUN));
        check("ar_stall",  32'(stall_cycles_a), 32'd0);
        check("ar_tmo_b",  32'(mem_timeout_b), 32'd0);
        idle_inputs();
        #1 reset = 1'b1;
        step();
        check("ar_post_ctl",   32'(ctl_a), 32'(CTL_NORMAL));
        check("ar_post_stall", 32'(stall_cycles_a), 32'd0);
        check("ar_post_state", 32'(dut_a.state), 32'(RUN));

        // Timeout on instance B: flag sets at the third edge spent in MEM_WAIT
        mem_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("tmo_flag%0d", i), 32'(mem_timeout_b), (i >= 3) ? 32'd1 : 32'd0);
        end
        check("tmo_wait_sat", 32'(dut_b.wait_cnt), 32'd3);
        check("tmo_stall_a",  32'(stall_cycles_a), 32'd6);
        check("tmo_ctl_b",    32'(ctl_b), 32'(CTL_MEMST));
        mem_ack = 1'b1;
        step();
        check("tmo_ack_state", 32'(dut_b.state), 32'(RUN));
        check("tmo_sticky",    32'(mem_timeout_b), 32'd1);
        idle_inputs();
        #1 reset = 1'b0;
        #1 check("tmo_cleared", 32'(mem_timeout_b), 32'd0);
        reset = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
